// File: rtl/data_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : data_memory_if
// Description : Load/store bus between the datapath and the data memory.
//               The byte-strobe signal be exists only when DMEM_BYTE_WRITE_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
interface data_memory_if;
    logic        we;   // write enable
    logic [31:0] a;    // byte address from the ALU
    logic [31:0] wd;   // write data (rs2)
    logic [31:0] rd;   // read data, combinational from a
`ifdef DMEM_BYTE_WRITE_EN
    logic [3:0]  be;   // per-byte write strobes

    modport master (output we, output a, output wd, output be, input rd);
    modport slave  (input we, input a, input wd, input be, output rd);
`else
    modport master (output we, output a, output wd, input rd);
    modport slave  (input we, input a, input wd, output rd);
`endif
endinterface
`default_nettype wire

// File: rtl/data_memory.sv
`default_nettype none
// ============================================================================
// Module      : data_memory
// Description : Word-organised data memory for the single-cycle RISC-V core.
//               Asynchronous read, write on rising clock edge, synchronous
//               active-low reset clearing every word.
//               Optional feature macro: DMEM_BYTE_WRITE_EN (per-byte strobes).
// Revision    : 1.0 - initial release
// ============================================================================
module data_memory #(
    parameter int DEPTH     = 4096,  // number of 32-bit words, power of two
    parameter int ADDR_BITS = 12     // log2(DEPTH)
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    data_memory_if.slave  bus
);

    logic [31:0]          mem_q [DEPTH];
    logic [ADDR_BITS-1:0] w_idx;
    logic [31:0]          word_d;
    logic                 w_unused;

    // Word index: byte offset and upper address bits are dropped, so
    // misaligned accesses hit the containing word and addresses alias.
    assign w_idx    = bus.a[ADDR_BITS+1:2];
    assign w_unused = &{1'b0, bus.a[31:ADDR_BITS+2], bus.a[1:0]};

    // Read path: pure lookup, no clock involved.
    assign bus.rd = mem_q[w_idx];

    // Word to be stored at the addressed location on a write.
    always_comb begin
`ifdef DMEM_BYTE_WRITE_EN
        word_d = mem_q[w_idx];
        for (int lane = 0; lane < 4; lane++) begin
            if (bus.be[lane]) begin
                word_d[8*lane +: 8] = bus.wd[8*lane +: 8];
            end
        end
`else
        word_d = bus.wd;
`endif
    end

    // Storage update: reset clears the array and overrides any write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (bus.we) begin
            mem_q[w_idx] <= word_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_data_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_data_memory
// Description : Directed self-checking bench for data_memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_data_memory;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    data_memory_if mem_bus ();

    data_memory #(
        .DEPTH     (4096),
        .ADDR_BITS (12)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (mem_bus.slave)
    );

    // Free-running clock, 10 time units per period.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_value(input string tag, input logic [31:0] obs,
                               input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h, expected %08h", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle away from it before sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Change address and let the combinational read settle.
    task automatic read_at(input logic [31:0] addr);
        mem_bus.a = addr;
        #1;
    endtask

    initial begin
        n_vec      = 0;
        n_err      = 0;
        rst_n      = 1'b0;
        mem_bus.we = 1'b0;
        mem_bus.a  = 32'h2000;
        mem_bus.wd = 32'h0;
`ifdef DMEM_BYTE_WRITE_EN
        mem_bus.be = 4'hF;
`endif
        tick();
        rst_n = 1'b1;
        #1;

        // Reset state
        read_at(32'h2000);  check_value("reset_2000", mem_bus.rd, 32'd0);
        read_at(32'h0010);  check_value("reset_0010", mem_bus.rd, 32'd0);

        // Simple write, old value visible before the edge
        mem_bus.a  = 32'h2000;
        mem_bus.wd = 32'd25;
        mem_bus.we = 1'b1;
        #1;
        check_value("rdw_before_edge", mem_bus.rd, 32'd0);
        tick();
        check_value("write_2000", mem_bus.rd, 32'd25);
        mem_bus.we = 1'b0;
        mem_bus.wd = 32'd99;
        tick();
        check_value("we0_hold_2000", mem_bus.rd, 32'd25);

        // Second address, no cross-corruption
        mem_bus.we = 1'b1;
        mem_bus.a  = 32'h10;
        mem_bus.wd = 32'd32;
        tick();
        check_value("write_0010", mem_bus.rd, 32'd32);
        mem_bus.we = 1'b0;
        read_at(32'h2000);  check_value("no_corrupt_2000", mem_bus.rd, 32'd25);

        // Aliasing and misalignment
        read_at(32'h4010);      check_value("alias_4010", mem_bus.rd, 32'd32);
        read_at(32'hFFFF_C010); check_value("alias_high", mem_bus.rd, 32'd32);
        read_at(32'h2003);      check_value("misalign_2003", mem_bus.rd, 32'd25);

        // Top word of the array
        mem_bus.we = 1'b1;
        mem_bus.a  = 32'h3FFC;
        mem_bus.wd = 32'hDEAD_BEEF;
        tick();
        mem_bus.we = 1'b0;
        check_value("top_word", mem_bus.rd, 32'hDEAD_BEEF);
        read_at(32'h0000);  check_value("word0_untouched", mem_bus.rd, 32'd0);

        // we=0 with moving address/data leaves memory alone
        mem_bus.a  = 32'h10;
        mem_bus.wd = 32'h1234_5678;
        tick();
        check_value("we0_hold_0010", mem_bus.rd, 32'd32);

        // Reset has priority over a simultaneous write and clears everything
        rst_n      = 1'b0;
        mem_bus.we = 1'b1;
        mem_bus.a  = 32'h10;
        mem_bus.wd = 32'd7;
        tick();
        rst_n      = 1'b1;
        mem_bus.we = 1'b0;
        #1;
        check_value("rst_drop_0010", mem_bus.rd, 32'd0);
        read_at(32'h2000);  check_value("rst_clear_2000", mem_bus.rd, 32'd0);
        read_at(32'h3FFC);  check_value("rst_clear_top", mem_bus.rd, 32'd0);

        // Writes work again after reset
        mem_bus.we = 1'b1;
        mem_bus.a  = 32'h20;
        mem_bus.wd = 32'hAABB_CCDD;
        tick();
        mem_bus.we = 1'b0;
        check_value("post_rst_write", mem_bus.rd, 32'hAABB_CCDD);

`ifdef DMEM_BYTE_WRITE_EN
        // Byte-lane strobes
        mem_bus.we = 1'b1;
        mem_bus.be = 4'b0010;
        mem_bus.wd = 32'h0000_EE00;
        tick();
        check_value("be_0010", mem_bus.rd, 32'hAABB_EEDD);
        mem_bus.be = 4'b0000;
        mem_bus.wd = 32'hFFFF_FFFF;
        tick();
        check_value("be_0000", mem_bus.rd, 32'hAABB_EEDD);
        mem_bus.be = 4'b1001;
        mem_bus.wd = 32'h1122_3344;
        tick();
        check_value("be_1001", mem_bus.rd, 32'h11BB_EE44);
        mem_bus.we = 1'b0;
        mem_bus.be = 4'hF;
`else
        // Full-word overwrite replaces all 32 bits
        mem_bus.we = 1'b1;
        mem_bus.wd = 32'h0000_EE00;
        tick();
        mem_bus.we = 1'b0;
        check_value("full_overwrite", mem_bus.rd, 32'h0000_EE00);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
